// File: rtl/cape_pad_arb_pkg.sv
// Shared definitions for the cape pad arbiter: register offsets, FSM states, pad mapping.
package cape_pad_arb_pkg;

    localparam int NUM_PADS = 28;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_GUARD  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_APPLY = 2'd2
    } arb_state_t;

    // UART n transmits on the even pad of its pair and receives on the odd one
    function automatic int tx_pad(input int n);
        return 2 * n;
    endfunction

    function automatic int rx_pad(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/cape_pad_arb_regs.sv
// APB register file for the cape pad arbiter: CTRL, STATUS (done is W1C), GUARD.
module cape_pad_arb_regs
    import cape_pad_arb_pkg::*;
#(
    parameter logic [7:0] GUARD_DEFAULT = 8'd16,
    parameter int         NUM_UART      = 4
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [7:0]          paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    input  logic [NUM_UART-1:0] applied,
    input  logic                busy,
    input  logic                done_set,
    output logic [NUM_UART-1:0] ctrl,
    output logic [7:0]          guard,
    output logic                done
);

    logic wr_en;
    logic unused_pwdata;

    assign wr_en         = psel & penable & pwrite;
    assign unused_pwdata = ^{pwdata[31:17], pwdata[15:8]};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl  <= '0;
            guard <= GUARD_DEFAULT;
            done  <= 1'b0;
        end else begin
            if (wr_en && paddr == ADDR_CTRL) begin
                ctrl <= pwdata[NUM_UART-1:0];
            end
            if (wr_en && paddr == ADDR_GUARD) begin
                guard <= pwdata[7:0];
            end
            // A completing switch outranks a simultaneous clear
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_en && paddr == ADDR_STATUS && pwdata[16]) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        prdata = '0;
        case (paddr)
            ADDR_CTRL:   prdata[NUM_UART-1:0] = ctrl;
            ADDR_STATUS: begin
                prdata[NUM_UART-1:0] = applied;
                prdata[8]            = busy;
                prdata[16]           = done;
            end
            ADDR_GUARD:  prdata[7:0] = guard;
            default:     prdata = '0;
        endcase
    end

endmodule

// File: rtl/cape_pad_arbiter.sv
// P8 pad ownership arbiter between MSS GPIO and UARTs, with a guarded break before each switch.
// Optional CAPE_PAD_ARB_RXSYNC_EN adds a 2-flop synchronizer on UART_RXD.
module cape_pad_arbiter
    import cape_pad_arb_pkg::*;
#(
    parameter logic [7:0] GUARD_DEFAULT = 8'd16,
    parameter int         NUM_UART      = 4
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    input  logic [27:0]         GPIO_OE,
    input  logic [27:0]         GPIO_OUT,
    output logic [27:0]         GPIO_IN,
    input  logic [NUM_UART-1:0] UART_TXD,
    output logic [NUM_UART-1:0] UART_RXD,
    output logic [27:0]         PAD_OE,
    output logic [27:0]         PAD_OUT,
    input  logic [27:0]         PAD_IN,
    output logic                IRQ
);

    arb_state_t          state;
    logic [NUM_UART-1:0] ctrl, applied, target;
    logic [NUM_UART-1:0] own_mask, brk_mask, rx_raw;
    logic [7:0]          guard, counter;
    logic                busy, done;

    assign busy = (state != ST_IDLE);

    cape_pad_arb_regs #(
        .GUARD_DEFAULT (GUARD_DEFAULT),
        .NUM_UART      (NUM_UART)
    ) u_regs (
        .pclk     (PCLK),
        .presetn  (PRESETN),
        .psel     (PSEL),
        .penable  (PENABLE),
        .pwrite   (PWRITE),
        .paddr    (PADDR),
        .pwdata   (PWDATA),
        .prdata   (PRDATA),
        .applied  (applied),
        .busy     (busy),
        .done_set (state == ST_APPLY),
        .ctrl     (ctrl),
        .guard    (guard),
        .done     (done)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state   <= ST_IDLE;
            applied <= '0;
            target  <= '0;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl != applied) begin
                        target  <= ctrl;
                        counter <= (guard == 8'd0) ? 8'd1 : guard;
                        state   <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (counter <= 8'd1) begin
                        counter <= '0;
                        state   <= ST_APPLY;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                ST_APPLY: begin
                    applied <= target;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The new ownership drives the pads already in APPLY so the break is exactly the guard length
    assign own_mask = (state == ST_APPLY) ? target : applied;
    assign brk_mask = (state == ST_BREAK) ? (applied ^ target) : '0;

    for (genvar n = 0; n < NUM_UART; n++) begin : g_uart
        localparam int TX = tx_pad(n);
        localparam int RX = rx_pad(n);

        assign PAD_OE[TX]  = brk_mask[n] ? 1'b0 : (own_mask[n] ? 1'b1 : GPIO_OE[TX]);
        assign PAD_OUT[TX] = (own_mask[n] && !brk_mask[n]) ? UART_TXD[n] : GPIO_OUT[TX];
        assign PAD_OE[RX]  = (brk_mask[n] || own_mask[n]) ? 1'b0 : GPIO_OE[RX];
        assign PAD_OUT[RX] = GPIO_OUT[RX];
        assign rx_raw[n]   = own_mask[n] ? PAD_IN[RX] : 1'b1;
    end

    if (2 * NUM_UART < NUM_PADS) begin : g_gpio_only
        assign PAD_OE[NUM_PADS-1:2*NUM_UART]  = GPIO_OE[NUM_PADS-1:2*NUM_UART];
        assign PAD_OUT[NUM_PADS-1:2*NUM_UART] = GPIO_OUT[NUM_PADS-1:2*NUM_UART];
    end

    assign GPIO_IN = PAD_IN;
    assign IRQ     = done;

`ifdef CAPE_PAD_ARB_RXSYNC_EN
    logic [NUM_UART-1:0] rx_meta, rx_sync;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_meta <= '1;
            rx_sync <= '1;
        end else begin
            rx_meta <= rx_raw;
            rx_sync <= rx_meta;
        end
    end

    assign UART_RXD = rx_sync;
`else
    assign UART_RXD = rx_raw;
`endif

endmodule

// File: tb/tb_cape_pad_arbiter.sv
// Directed self-checking bench for cape_pad_arbiter (honours CAPE_PAD_ARB_RXSYNC_EN if defined).
module tb_cape_pad_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic [27:0] GPIO_OE = '0, GPIO_OUT = '0, PAD_IN = '0;
    logic [27:0] GPIO_IN, PAD_OE, PAD_OUT;
    logic [3:0]  UART_TXD = 4'h0;
    logic [3:0]  UART_RXD;
    logic        IRQ;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef CAPE_PAD_ARB_RXSYNC_EN
    localparam int RX_LAT = 2;
`else
    localparam int RX_LAT = 0;
`endif

    always #5 PCLK = ~PCLK;

    cape_pad_arbiter #(.GUARD_DEFAULT(8'd16), .NUM_UART(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .GPIO_OE(GPIO_OE), .GPIO_OUT(GPIO_OUT), .GPIO_IN(GPIO_IN),
        .UART_TXD(UART_TXD), .UART_RXD(UART_RXD),
        .PAD_OE(PAD_OE), .PAD_OUT(PAD_OUT), .PAD_IN(PAD_IN), .IRQ(IRQ)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        PADDR = a;
        #1;
        d = PRDATA;
    endtask

    task automatic wait_applied(input logic [3:0] exp, input int budget);
        logic [31:0] rd;
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            apb_read(8'h04, rd);
            if (rd[3:0] == exp) begin hit = 1; break; end
            tick();
        end
        n_checks++;
        if (!hit) $display("FAIL wait_applied: applied=%h required %h within %0d cycles", rd[3:0], exp, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        GPIO_OE = 28'h5A5A5A5; GPIO_OUT = 28'hC3C3C3C; PAD_IN = 28'h1234567; UART_TXD = 4'hF;
        PRESETN = 1'b0;
        #12;
        n_checks++; if (PAD_OE !== 28'h5A5A5A5) $display("FAIL reset_pad_oe: got %h expected %h", PAD_OE, 28'h5A5A5A5); else n_pass++;
        n_checks++; if (PAD_OUT !== 28'hC3C3C3C) $display("FAIL reset_pad_out: got %h expected %h", PAD_OUT, 28'hC3C3C3C); else n_pass++;
        n_checks++; if (UART_RXD !== 4'hF) $display("FAIL reset_rxd: got %h expected %h", UART_RXD, 4'hF); else n_pass++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ); else n_pass++;
        n_checks++; if (GPIO_IN !== 28'h1234567) $display("FAIL reset_gpio_in: got %h expected %h", GPIO_IN, 28'h1234567); else n_pass++;
        tick(); tick();
        PRESETN = 1'b1;
        tick();
        apb_read(8'h00, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", rd); else n_pass++;
        apb_read(8'h04, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_status: got %h expected 0", rd); else n_pass++;
        apb_read(8'h08, rd);
        n_checks++; if (rd !== 32'h10) $display("FAIL reset_guard: got %h expected 10", rd); else n_pass++;
        apb_write(8'h0C, 32'hFFFF_FFFF);
        apb_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h expected 0", rd); else n_pass++;
    endtask

    task automatic test_first_switch();
        int len = 0;
        bit seen = 0;
        logic [31:0] rd;
        GPIO_OE = 28'hFFFFFFF; GPIO_OUT = 28'h0; UART_TXD = 4'h0;
        apb_write(8'h08, 32'd4);
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 40; i++) begin
            if (PAD_OE[0] === 1'b0) begin len++; seen = 1; end
            else if (seen) break;
            tick();
        end
        n_checks++; if (len != 4) $display("FAIL break_len_g4: got %0d cycles expected 4", len); else n_pass++;
        n_checks++; if (PAD_OE[0] !== 1'b1) $display("FAIL tx_oe_owned: got %b expected 1", PAD_OE[0]); else n_pass++;
        UART_TXD = 4'h1; #1;
        n_checks++; if (PAD_OUT[0] !== 1'b1) $display("FAIL tx_out_hi: got %b expected 1", PAD_OUT[0]); else n_pass++;
        UART_TXD = 4'h0; #1;
        n_checks++; if (PAD_OUT[0] !== 1'b0) $display("FAIL tx_out_lo: got %b expected 0", PAD_OUT[0]); else n_pass++;
        n_checks++; if (PAD_OE[1] !== 1'b0) $display("FAIL rx_oe_owned: got %b expected 0", PAD_OE[1]); else n_pass++;
        tick();
        apb_read(8'h04, rd);
        n_checks++; if (rd !== 32'h0001_0001) $display("FAIL status_after_switch: got %h expected 00010001", rd); else n_pass++;
        n_checks++; if (IRQ !== 1'b1) $display("FAIL irq_set: got %b expected 1", IRQ); else n_pass++;
    endtask

    task automatic test_w1c_and_noop();
        logic [31:0] rd;
        int busy_cnt = 0;
        apb_write(8'h04, 32'h0001_0000);
        n_checks++; if (IRQ !== 1'b0) $display("FAIL irq_w1c: got %b expected 0", IRQ); else n_pass++;
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 6; i++) begin
            apb_read(8'h04, rd);
            if (rd[8]) busy_cnt++;
            tick();
        end
        n_checks++; if (busy_cnt != 0) $display("FAIL noop_busy: got %0d busy cycles expected 0", busy_cnt); else n_pass++;
        apb_read(8'h04, rd);
        n_checks++; if (rd !== 32'h0000_0001) $display("FAIL noop_status: got %h expected 00000001", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        GPIO_OE = 28'hFFFFFFE;
        apb_write(8'h00, 32'h3);
        apb_write(8'h00, 32'h2);
        n_checks++; if (PAD_OE[2] !== 1'b0) $display("FAIL b2b_first_break_pad2: got %b expected 0", PAD_OE[2]); else n_pass++;
        n_checks++; if (PAD_OE[0] !== 1'b1) $display("FAIL b2b_first_keep_pad0: got %b expected 1", PAD_OE[0]); else n_pass++;
        apb_read(8'h04, rd);
        n_checks++; if (rd[8] !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", rd[8]); else n_pass++;
        wait_applied(4'h3, 40);
        tick();
        n_checks++; if (PAD_OE[1:0] !== 2'b00) $display("FAIL b2b_second_break_pad01: got %b expected 00", PAD_OE[1:0]); else n_pass++;
        n_checks++; if (PAD_OE[3:2] !== 2'b01) $display("FAIL b2b_second_keep_pad23: got %b expected 01", PAD_OE[3:2]); else n_pass++;
        wait_applied(4'h2, 40);
        n_checks++; if (PAD_OE[1:0] !== 2'b10) $display("FAIL b2b_final_pad01: got %b expected 10", PAD_OE[1:0]); else n_pass++;
        n_checks++; if (PAD_OE[3:2] !== 2'b01) $display("FAIL b2b_final_pad23: got %b expected 01", PAD_OE[3:2]); else n_pass++;
    endtask

    task automatic test_guard_zero();
        logic [31:0] rd;
        int zero_cnt = 0;
        int upper_bad = 0;
        apb_write(8'h00, 32'h0);
        wait_applied(4'h0, 40);
        apb_write(8'h08, 32'h0);
        apb_read(8'h08, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL guard_zero_read: got %h expected 0", rd); else n_pass++;
        apb_write(8'h00, 32'hF);
        for (int i = 0; i < 8; i++) begin
            GPIO_OE  = {20'(i * 12345 + 7), 8'hFF};
            GPIO_OUT = {20'(i * 777 + 3), 8'h00};
            #1;
            if (PAD_OE[7:0] === 8'h00) zero_cnt++;
            if (PAD_OE[27:8] !== GPIO_OE[27:8] || PAD_OUT[27:8] !== GPIO_OUT[27:8]) upper_bad++;
            tick();
        end
        n_checks++; if (zero_cnt != 1) $display("FAIL g0_break_len: got %0d cycles expected 1", zero_cnt); else n_pass++;
        n_checks++; if (upper_bad != 0) $display("FAIL g0_upper_follow: got %0d bad cycles expected 0", upper_bad); else n_pass++;
        n_checks++; if (PAD_OE[7:0] !== 8'h55) $display("FAIL g0_final_oe: got %h expected 55", PAD_OE[7:0]); else n_pass++;
        apb_read(8'h04, rd);
        n_checks++; if (rd[3:0] !== 4'hF) $display("FAIL g0_applied: got %h expected f", rd[3:0]); else n_pass++;
    endtask

    task automatic test_reset_mid_break();
        logic [31:0] rd;
        int bad = 0;
        GPIO_OE = 28'hFFFFFFF; GPIO_OUT = 28'h0A5A5A5;
        apb_write(8'h08, 32'd16);
        apb_write(8'h00, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (PAD_OE[2] !== 1'b0) $display("FAIL midbrk_in_break: got %b expected 0", PAD_OE[2]); else n_pass++;
        PRESETN = 1'b0;
        #2;
        n_checks++; if (PAD_OE !== GPIO_OE) $display("FAIL midbrk_pad_oe: got %h expected %h", PAD_OE, GPIO_OE); else n_pass++;
        n_checks++; if (PAD_OUT !== GPIO_OUT) $display("FAIL midbrk_pad_out: got %h expected %h", PAD_OUT, GPIO_OUT); else n_pass++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL midbrk_irq: got %b expected 0", IRQ); else n_pass++;
        apb_read(8'h04, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL midbrk_status: got %h expected 0", rd); else n_pass++;
        tick(); tick();
        PRESETN = 1'b1;
        for (int i = 0; i < 25; i++) begin
            apb_read(8'h04, rd);
            if (PAD_OE !== GPIO_OE || IRQ !== 1'b0 || rd !== 32'h0) bad++;
            tick();
        end
        n_checks++; if (bad != 0) $display("FAIL midbrk_no_apply: got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

    task automatic test_rx_path();
        apb_write(8'h08, 32'd2);
        apb_write(8'h00, 32'h1);
        wait_applied(4'h1, 30);
        PAD_IN = 28'hFFFFFFF;
        tick(); tick(); tick();
        PAD_IN[1] = 1'b0;
        PAD_IN[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (UART_RXD[0] !== ((k >= RX_LAT) ? 1'b0 : 1'b1))
                $display("FAIL rx0_step%0d: got %b expected %b", k, UART_RXD[0], (k >= RX_LAT) ? 1'b0 : 1'b1);
            else n_pass++;
            n_checks++; if (UART_RXD[1] !== 1'b1) $display("FAIL rx1_unowned_step%0d: got %b expected 1", k, UART_RXD[1]); else n_pass++;
            @(posedge PCLK);
        end
        #1;
        n_checks++; if (GPIO_IN !== PAD_IN) $display("FAIL gpio_in_follow: got %h expected %h", GPIO_IN, PAD_IN); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_switch();
        test_w1c_and_noop();
        test_back_to_back();
        test_guard_zero();
        test_reset_mid_break();
        test_rx_path();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
